// File: rtl/systolic_sort.sv
// Insertion sorter: words are placed in order as they arrive, then drained from entry 0.
module systolic_sort #(
    parameter int WIDTH  = 8,
    parameter int NUMBER = 16,
    parameter bit SIGNED = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_a,
    output logic                         ready_a,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         last_a,
    input  logic                         desc_i,
    output logic                         valid_b,
    input  logic                         ready_b,
    output logic [WIDTH-1:0]             data_o,
    output logic                         last_b,
    output logic [$clog2(NUMBER+1)-1:0]  len_o
);
    localparam int CW = $clog2(NUMBER+1);

    typedef enum logic {LOAD, DRAIN} state_t;

    state_t                         state, state_nxt;
    logic [NUMBER-1:0][WIDTH-1:0]   mem;
    logic [NUMBER-1:0][WIDTH-1:0]   mem_up;
    logic [NUMBER-1:0][WIDTH-1:0]   mem_ins;
    logic [NUMBER-1:0]              after;
    logic [NUMBER-1:0]              after_prev;
    logic [CW-1:0]                  count;
    logic [CW-1:0]                  len;
    logic                           desc_q;
    logic                           acc_in, acc_out, closing;

    // True when held entry e must sit after incoming word x (equal words stay ahead).
    function automatic logic later(input logic [WIDTH-1:0] e, input logic [WIDTH-1:0] x,
                                   input logic d);
        logic gt, lt;
        if (SIGNED) begin
            gt = $signed(e) > $signed(x);
            lt = $signed(e) < $signed(x);
        end else begin
            gt = e > x;
            lt = e < x;
        end
        return d ? lt : gt;
    endfunction

    assign ready_a  = (state == LOAD) && !rst;
    assign valid_b  = (state == DRAIN);
    assign acc_in   = valid_a && ready_a;
    assign acc_out  = valid_b && ready_b;
    assign closing  = acc_in && (last_a || count == CW'(NUMBER-1));
    assign data_o   = mem[0];
    assign last_b   = valid_b && (count == CW'(1));
    assign len_o    = len;

    // Parallel compare: empty slots always count as "after" so the word lands at the tail.
    always_comb begin
        after = '0;
        for (int i = 0; i < NUMBER; i++)
            after[i] = (CW'(i) >= count) || later(mem[i], data_i, desc_q);
    end

    assign after_prev = {after[NUMBER-2:0], 1'b0};
    assign mem_up     = {mem[NUMBER-2:0], data_i};

    // Shift: the first "after" slot takes the new word, later slots take their neighbour.
    always_comb begin
        mem_ins = mem;
        for (int i = 0; i < NUMBER; i++)
            if (after[i]) mem_ins[i] = after_prev[i] ? mem_up[i] : data_i;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LOAD;
        else     state <= state_nxt;
    end

    // Next state: close a frame on last/full, reopen after the final drain accept.
    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (closing) state_nxt = DRAIN;
            DRAIN:   if (acc_out && count == CW'(1)) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    // Array, count, length and sort-order registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem    <= '0;
            count  <= '0;
            len    <= '0;
            desc_q <= 1'b0;
        end else if (acc_in) begin
            mem   <= mem_ins;
            count <= count + CW'(1);
            if (count == '0) desc_q <= desc_i;
            if (closing)     len    <= count + CW'(1);
        end else if (acc_out) begin
            mem   <= {WIDTH'(0), mem[NUMBER-1:1]};
            count <= count - CW'(1);
        end
    end
endmodule

// File: tb/tb_systolic_sort.sv
// Directed bench for systolic_sort: one unsigned and one signed instance share stimulus.
module tb_systolic_sort;
    logic       clk = 1'b0;
    logic       rst;
    logic       valid_a, last_a, desc_i, ready_b;
    logic [7:0] data_i;
    logic       ready_a, valid_b, last_b;
    logic [7:0] data_o;
    logic [4:0] len_o;
    logic       s_ready_a, s_valid_b, s_last_b;
    logic [7:0] s_data_o;
    logic [4:0] s_len_o;
    int         passed = 0;
    int         total  = 0;

    always #5 clk = ~clk;

    systolic_sort #(.WIDTH(8), .NUMBER(16), .SIGNED(1'b0)) u_dut (
        .clk(clk), .rst(rst), .valid_a(valid_a), .ready_a(ready_a), .data_i(data_i),
        .last_a(last_a), .desc_i(desc_i), .valid_b(valid_b), .ready_b(ready_b),
        .data_o(data_o), .last_b(last_b), .len_o(len_o));

    systolic_sort #(.WIDTH(8), .NUMBER(16), .SIGNED(1'b1)) u_sdut (
        .clk(clk), .rst(rst), .valid_a(valid_a), .ready_a(s_ready_a), .data_i(data_i),
        .last_a(last_a), .desc_i(desc_i), .valid_b(s_valid_b), .ready_b(ready_b),
        .data_o(s_data_o), .last_b(s_last_b), .len_o(s_len_o));

    // Present one word in the low phase; it is accepted at the following rising edge.
    task automatic put(input logic [7:0] w, input logic l, input logic d);
        @(negedge clk);
        valid_a = 1'b1; data_i = w; last_a = l; desc_i = d;
        @(posedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; valid_a = 0; last_a = 0; desc_i = 0; ready_b = 0; data_i = 0;
        @(negedge clk); @(negedge clk);
        total++; if ({ready_a, valid_b, last_b} !== 3'b000) $display("FAIL reset_hs got %b want 000", {ready_a, valid_b, last_b}); else passed++;
        total++; if (data_o !== 8'h00 || len_o !== 5'd0) $display("FAIL reset_data got %h/%0d want 00/0", data_o, len_o); else passed++;
        rst = 1'b0;
        @(negedge clk);
        total++; if (ready_a !== 1'b1) $display("FAIL reset_release ready_a got %b want 1", ready_a); else passed++;
    endtask

    // 5,1,9,1 ascending; desc_i toggled after the first word must be ignored.
    task automatic test_ascending();
        logic [7:0] exp [4];
        exp = '{8'd1, 8'd1, 8'd5, 8'd9};
        put(8'd5, 0, 0); put(8'd1, 0, 1); put(8'd9, 0, 1); put(8'd1, 1, 1);
        @(negedge clk); valid_a = 0; last_a = 0; ready_b = 1;
        total++; if (valid_b !== 1'b1 || ready_a !== 1'b0) $display("FAIL asc_latency valid_b/ready_a got %b%b want 10", valid_b, ready_a); else passed++;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            total++; if (data_o !== exp[k] || last_b !== (k == 3) || len_o !== 5'd4)
                $display("FAIL asc_out%0d got %0d/%b/%0d want %0d/%b/4", k, data_o, last_b, len_o, exp[k], k == 3); else passed++;
        end
        @(negedge clk); ready_b = 0;
        total++; if (ready_a !== 1'b1 || valid_b !== 1'b0) $display("FAIL asc_return got %b%b want 10", ready_a, valid_b); else passed++;
    endtask

    // Descending on 80,01,7F: signed gives 7F,01,80; unsigned gives 80,7F,01.
    task automatic test_signed_desc();
        logic [7:0] exp_s [3];
        logic [7:0] exp_u [3];
        exp_s = '{8'h7F, 8'h01, 8'h80};
        exp_u = '{8'h80, 8'h7F, 8'h01};
        put(8'h80, 0, 1); put(8'h01, 0, 0); put(8'h7F, 1, 0);
        @(negedge clk); valid_a = 0; last_a = 0; ready_b = 1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            total++; if (s_valid_b !== 1'b1 || s_data_o !== exp_s[k] || s_last_b !== (k == 2) || s_len_o !== 5'd3)
                $display("FAIL sdesc_out%0d got %h/%b want %h/%b", k, s_data_o, s_last_b, exp_s[k], k == 2); else passed++;
            total++; if (data_o !== exp_u[k]) $display("FAIL udesc_out%0d got %h want %h", k, data_o, exp_u[k]); else passed++;
        end
        @(negedge clk); ready_b = 0;
    endtask

    // 16 words with no last_a: implicit close, 17th word held off until drain ends.
    task automatic test_implicit_full();
        for (int i = 0; i < 16; i++) put(8'((i * 7) % 16), 0, 0);
        @(negedge clk); data_i = 8'd99; last_a = 1; ready_b = 1;
        total++; if (valid_b !== 1'b1 || ready_a !== 1'b0) $display("FAIL full_close got %b%b want 10", valid_b, ready_a); else passed++;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            total++; if (data_o !== 8'(k) || last_b !== (k == 15) || len_o !== 5'd16 || ready_a !== 1'b0)
                $display("FAIL full_out%0d got %0d/%b/%0d/%b want %0d/%b/16/0", k, data_o, last_b, len_o, ready_a, k, k == 15); else passed++;
        end
        @(negedge clk); valid_a = 0; last_a = 0; ready_b = 0;
        total++; if (ready_a !== 1'b1 || valid_b !== 1'b0) $display("FAIL full_return got %b%b want 10", ready_a, valid_b); else passed++;
    endtask

    // Drain of 3,2 under a 0101 ready_b pattern: outputs hold while stalled.
    task automatic test_back_to_back();
        logic [7:0] exp_d [4];
        logic       exp_l [4];
        logic       rb    [4];
        exp_d = '{8'd2, 8'd2, 8'd3, 8'd3};
        exp_l = '{1'b0, 1'b0, 1'b1, 1'b1};
        rb    = '{1'b0, 1'b1, 1'b0, 1'b1};
        put(8'd3, 0, 0); put(8'd2, 1, 0);
        @(negedge clk); valid_a = 0; last_a = 0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            ready_b = rb[k];
            total++; if (valid_b !== 1'b1 || data_o !== exp_d[k] || last_b !== exp_l[k] || len_o !== 5'd2)
                $display("FAIL stall_c%0d got %b/%0d/%b/%0d want 1/%0d/%b/2", k, valid_b, data_o, last_b, len_o, exp_d[k], exp_l[k]); else passed++;
        end
        @(negedge clk); ready_b = 0;
        total++; if (ready_a !== 1'b1 || valid_b !== 1'b0) $display("FAIL stall_return got %b%b want 10", ready_a, valid_b); else passed++;
    endtask

    task automatic test_single();
        put(8'd42, 1, 0);
        @(negedge clk); valid_a = 0; last_a = 0; ready_b = 1;
        total++; if (valid_b !== 1'b1 || data_o !== 8'd42 || last_b !== 1'b1 || len_o !== 5'd1)
            $display("FAIL single got %b/%0d/%b/%0d want 1/42/1/1", valid_b, data_o, last_b, len_o); else passed++;
        @(negedge clk); ready_b = 0;
        total++; if (ready_a !== 1'b1 || valid_b !== 1'b0) $display("FAIL single_return got %b%b want 10", ready_a, valid_b); else passed++;
    endtask

    // Reset in the middle of a drain, then a clean frame 7,6.
    task automatic test_reset_mid_drain();
        put(8'd30, 0, 0); put(8'd10, 0, 0); put(8'd20, 1, 0);
        @(negedge clk); valid_a = 0; last_a = 0; ready_b = 1;
        total++; if (data_o !== 8'd10) $display("FAIL rmd_out0 got %0d want 10", data_o); else passed++;
        @(negedge clk);
        total++; if (data_o !== 8'd20) $display("FAIL rmd_out1 got %0d want 20", data_o); else passed++;
        @(negedge clk); ready_b = 0;
        total++; if (data_o !== 8'd30 || last_b !== 1'b1) $display("FAIL rmd_out2 got %0d/%b want 30/1", data_o, last_b); else passed++;
        rst = 1'b1;
        #1;
        total++; if (valid_b !== 1'b0 || last_b !== 1'b0) $display("FAIL rmd_rst got %b%b want 00", valid_b, last_b); else passed++;
        @(negedge clk); rst = 1'b0;
        put(8'd7, 0, 0); put(8'd6, 1, 0);
        @(negedge clk); valid_a = 0; last_a = 0; ready_b = 1;
        total++; if (valid_b !== 1'b1 || data_o !== 8'd6 || last_b !== 1'b0 || len_o !== 5'd2)
            $display("FAIL rmd_new0 got %b/%0d/%b/%0d want 1/6/0/2", valid_b, data_o, last_b, len_o); else passed++;
        @(negedge clk);
        total++; if (data_o !== 8'd7 || last_b !== 1'b1) $display("FAIL rmd_new1 got %0d/%b want 7/1", data_o, last_b); else passed++;
        @(negedge clk); ready_b = 0;
        total++; if (valid_b !== 1'b0 || ready_a !== 1'b1) $display("FAIL rmd_return got %b%b want 01", valid_b, ready_a); else passed++;
    endtask

    initial begin
        test_reset();
        test_ascending();
        test_signed_desc();
        test_implicit_full();
        test_back_to_back();
        test_single();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1, "timeout");
    end
endmodule
